// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: pixel width, Q15.16 pixel type,
// default kernel edge and common fixed-point constants.
`timescale 1ns/1ps
package conv_pkg;

    localparam int DW           = 32;
    localparam int SIZE_DEFAULT = 7;

    typedef logic signed [DW-1:0] pix_t;  // Q15.16

    localparam pix_t FX_ONE  = 32'h0001_0000;
    localparam pix_t FX_ZERO = '0;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out stream bundle for conv_window_gen.
// master = upstream pixel source plus downstream window sink; slave = the generator.
// win_last is present only when CONV_WIN_LAST_EN is defined.
`timescale 1ns/1ps
interface conv_window_gen_if #(
    parameter int SIZE = conv_pkg::SIZE_DEFAULT,
    parameter int DW   = conv_pkg::DW
);

    logic                     in_valid;
    logic                     in_ready;
    logic [DW-1:0]            in_data;
    logic                     win_valid;
    logic                     win_ready;
    logic [SIZE*SIZE*DW-1:0]  win_data;
`ifdef CONV_WIN_LAST_EN
    logic                     win_last;

    modport master (
        output in_valid, in_data, win_ready,
        input  in_ready, win_valid, win_data, win_last
    );

    modport slave (
        input  in_valid, in_data, win_ready,
        output in_ready, win_valid, win_data, win_last
    );
`else
    modport master (
        output in_valid, in_data, win_ready,
        input  in_ready, win_valid, win_data
    );

    modport slave (
        input  in_valid, in_data, win_ready,
        output in_ready, win_valid, win_data
    );
`endif

endinterface

// File: rtl/conv_line_buf.sv
// One image row of pixels, addressed by column. The read port is combinational on
// the current address, so a read in the same cycle as a write returns the old value.
`timescale 1ns/1ps
module conv_line_buf #(
    parameter int IMG_W = 28,
    parameter int DW    = conv_pkg::DW,
    parameter int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [IMG_W];

    // Row storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming SIZE x SIZE sliding-window generator (stride 1, no padding) feeding conv.
// Pixels arrive in raster order; the last SIZE-1 rows live in line buffers and a
// SIZE x SIZE shift register holds the current neighbourhood. A window is emitted
// once the accepted pixel completes a full neighbourhood of the current frame.
// Optional feature: define CONV_WIN_LAST_EN to add win_last, flagging the final
// window of each frame.
`timescale 1ns/1ps
module conv_window_gen #(
    parameter int SIZE  = conv_pkg::SIZE_DEFAULT,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = conv_pkg::DW
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_window_gen_if.slave  bus
);

    import conv_pkg::*;

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int WW = SIZE * SIZE * DW;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_EMIT = CW'(SIZE - 1);
    localparam logic [RW-1:0] ROW_EMIT = RW'(SIZE - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          emit;

    logic [DW-1:0] lb_rd   [SIZE-1];
    logic [DW-1:0] win_q   [SIZE][SIZE];
    logic [DW-1:0] win_nxt [SIZE][SIZE];
    logic [WW-1:0] win_flat;

    logic          win_valid_q;
    logic [WW-1:0] win_data_q;

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.in_ready  = !win_valid_q || bus.win_ready;
    assign emit          = accept && (row >= ROW_EMIT) && (col >= COL_EMIT);
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = win_data_q;

    // Raster position of the next pixel; wraps straight into the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffer chain: each accepted pixel pushes its column up by one row,
    // with buffer SIZE-2 receiving the incoming pixel (the most recent row).
    for (genvar k = 0; k < SIZE - 1; k++) begin : g_lb
        logic [DW-1:0] wdata;

        if (k == SIZE - 2) begin : g_top
            assign wdata = bus.in_data;
        end else begin : g_mid
            assign wdata = lb_rd[k+1];
        end

        conv_line_buf #(
            .IMG_W (IMG_W),
            .DW    (DW),
            .AW    (CW)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (col),
            .wdata (wdata),
            .rdata (lb_rd[k])
        );
    end

    // Next neighbourhood: shift every row left, new right column from the
    // pre-write line-buffer values plus the incoming pixel at the bottom.
    always_comb begin
        win_nxt = win_q;
        for (int unsigned r = 0; r < SIZE; r++) begin
            for (int unsigned c = 0; c < SIZE - 1; c++) begin
                win_nxt[r][c] = win_q[r][c+1];
            end
        end
        for (int unsigned r = 0; r < SIZE - 1; r++) begin
            win_nxt[r][SIZE-1] = lb_rd[r];
        end
        win_nxt[SIZE-1][SIZE-1] = bus.in_data;
    end

    // Flatten to conv element order: element r*SIZE+c at bits [k*DW +: DW].
    always_comb begin
        win_flat = '0;
        for (int unsigned r = 0; r < SIZE; r++) begin
            for (int unsigned c = 0; c < SIZE; c++) begin
                win_flat[(r*SIZE + c)*DW +: DW] = win_nxt[r][c];
            end
        end
    end

    // Neighbourhood shift register, advanced on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < SIZE; r++) begin
                for (int unsigned c = 0; c < SIZE; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            win_q <= win_nxt;
        end
    end

    // Single output register: load on emit, drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
        end else if (emit) begin
            win_valid_q <= 1'b1;
            win_data_q  <= win_flat;
        end else if (bus.win_ready) begin
            win_valid_q <= 1'b0;
        end
    end

`ifdef CONV_WIN_LAST_EN
    logic win_last_q;

    assign bus.win_last = win_last_q;

    // End-of-frame flag, captured with the window it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_last_q <= 1'b0;
        end else if (emit) begin
            win_last_q <= (row == ROW_LAST) && (col == COL_LAST);
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 3x3 kernel over a 4x4 image for the
// streaming, stall, back-to-back frame and mid-frame reset cases, plus a default
// 7x7 over 28x28 instance streamed with FX_ONE.
`timescale 1ns/1ps
module tb_conv_window_gen;

    import conv_pkg::*;

    localparam int S_WW = 3 * 3 * 32;
    localparam int B_WW = 7 * 7 * 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    conv_window_gen_if #(.SIZE(3), .DW(32)) s_bus ();
    conv_window_gen_if #(.SIZE(7), .DW(32)) b_bus ();

    conv_window_gen #(
        .SIZE  (3),
        .IMG_W (4),
        .IMG_H (4),
        .DW    (32)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_bus)
    );

    conv_window_gen #(
        .SIZE  (7),
        .IMG_W (28),
        .IMG_H (28),
        .DW    (32)
    ) u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [B_WW-1:0] obs, input logic [B_WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected 3x3 window over a 4x4 frame whose pixel (r,c) holds off + r*4 + c;
    // b is the raster index of the window's top-left pixel.
    function automatic logic [S_WW-1:0] swin(input int b, input int off);
        logic [S_WW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[(r*3 + c)*32 +: 32] = 32'(off + b + r*4 + c);
            end
        end
        return w;
    endfunction

    task automatic push_s(input logic [31:0] v);
        s_bus.in_valid = 1'b1;
        s_bus.in_data  = v;
        @(posedge clk);
        #1;
        s_bus.in_valid = 1'b0;
    endtask

    task automatic check_after(input int p, input int off, input string tag);
        int r;
        int c;
        bit ev;
        r  = p / 4;
        c  = p % 4;
        ev = (r >= 2) && (c >= 2);
        check({tag, "_valid"}, B_WW'(s_bus.win_valid), B_WW'(ev));
        if (ev) begin
            check({tag, "_data"}, B_WW'(s_bus.win_data), B_WW'(swin((r-2)*4 + (c-2), off)));
`ifdef CONV_WIN_LAST_EN
            check({tag, "_last"}, B_WW'(s_bus.win_last), B_WW'(p == 15));
`endif
        end
    endtask

    task automatic run_frame(input int off, input string tag, input bit stall);
        for (int p = 0; p < 16; p++) begin
            if (stall && p == 11) begin
                s_bus.win_ready = 1'b0;
                s_bus.in_valid  = 1'b1;
                s_bus.in_data   = 32'(off + 11);
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk);
                    #1;
                    check("stall_in_ready", B_WW'(s_bus.in_ready), B_WW'(1'b0));
                    check("stall_valid", B_WW'(s_bus.win_valid), B_WW'(1'b1));
                    check("stall_data", B_WW'(s_bus.win_data), B_WW'(swin(0, off)));
                end
                s_bus.win_ready = 1'b1;
            end
            push_s(32'(off + p));
            check_after(p, off, tag);
        end
    endtask

    logic [B_WW-1:0] ones;
    int              nwin;

    initial begin
        s_bus.in_valid  = 1'b0;
        s_bus.in_data   = '0;
        s_bus.win_ready = 1'b1;
        b_bus.in_valid  = 1'b0;
        b_bus.in_data   = '0;
        b_bus.win_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_in_ready", B_WW'(s_bus.in_ready), B_WW'(1'b1));
        check("rst_s_valid", B_WW'(s_bus.win_valid), B_WW'(1'b0));
        check("rst_s_data", B_WW'(s_bus.win_data), '0);
        check("rst_b_valid", B_WW'(b_bus.win_valid), B_WW'(1'b0));
        check("rst_b_data", b_bus.win_data, '0);
`ifdef CONV_WIN_LAST_EN
        check("rst_s_last", B_WW'(s_bus.win_last), B_WW'(1'b0));
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain streaming, then with a 5-cycle downstream stall, then a new frame
        run_frame(0, "f0", 1'b0);
        run_frame(0, "stall", 1'b1);
        run_frame(100, "f100", 1'b0);

        // Reset part way through a frame
        for (int p = 0; p < 8; p++) begin
            push_s(32'(p));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", B_WW'(s_bus.win_valid), B_WW'(1'b0));
        check("midrst_in_ready", B_WW'(s_bus.in_ready), B_WW'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(0, "after_rst", 1'b0);

        // Default geometry, constant FX_ONE image
        ones = '0;
        for (int k = 0; k < 49; k++) begin
            ones[k*32 +: 32] = FX_ONE;
        end
        nwin = 0;
        for (int i = 0; i < 28*28; i++) begin
            b_bus.in_valid = 1'b1;
            b_bus.in_data  = FX_ONE;
            @(posedge clk);
            #1;
            if (b_bus.win_valid) begin
                nwin++;
                check("big_data", b_bus.win_data, ones);
`ifdef CONV_WIN_LAST_EN
                check("big_last", B_WW'(b_bus.win_last), B_WW'(nwin == 484));
`endif
            end
        end
        b_bus.in_valid = 1'b0;
        check("big_count", B_WW'(nwin), B_WW'(484));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
